gsr_pur_ctrl: RTL and testbench

Generates the global set/reset (GSR) and power-up reset (PUR) nets that primitive simulation models such as I/O DDR cells consume as active-low tri1-style inputs. It provides a stretched power-up reset after board reset, plus a user-requestable GSR pulse with a guaranteed minimum width. It also provides the combined set/reset-not (SRN) term that those primitives compute from GSR and PUR. It sits once at the top of the design, and its outputs fan out to every primitive with a GSR option.

---
 rtl/gsr_pur_ctrl_if.sv | 33 +++
 rtl/gsr_pur_ctrl.sv | 101 ++++++++++
 tb/tb_gsr_pur_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/gsr_pur_ctrl_if.sv
// gsr_pur_ctrl_if
// Groups the global reset nets produced by gsr_pur_ctrl with the user GSR
// request that feeds it.
//   GSRN_REQ  user GSR request, active-low, asynchronous to SCLK
//   GSR_sig   global set/reset net, active-low
//   PUR_sig   power-up reset net, active-low
//   SRN       combined set/reset-not term seen by GSR-capable primitives
//   READY     high once both GSR_sig and PUR_sig are released
// master: the requesting side (drives GSRN_REQ, observes the nets).
// slave : the controller (samples GSRN_REQ, drives the nets).
interface gsr_pur_ctrl_if;
  logic GSRN_REQ;
  logic GSR_sig;
  logic PUR_sig;
  logic SRN;
  logic READY;

  modport master (
    output GSRN_REQ,
    input  GSR_sig,
    input  PUR_sig,
    input  SRN,
    input  READY
  );

  modport slave (
    input  GSRN_REQ,
    output GSR_sig,
    output PUR_sig,
    output SRN,
    output READY
  );
endinterface

// File: rtl/gsr_pur_ctrl.sv
// gsr_pur_ctrl
// Produces the active-low global set/reset (GSR) and power-up reset (PUR)
// nets for primitive models. PUR is held low for PUR_CYCLES edges after the
// synchronized release of RSTN; GSR is pulsed low on user request with a
// minimum width of GSR_MIN_CYCLES.
// Ports:
//   SCLK  system clock, rising edge
//   RSTN  asynchronous assert, active-low reset; release synchronized inside
//   bus   gsr_pur_ctrl_if.slave (GSRN_REQ in; GSR_sig, PUR_sig, SRN, READY out)
// GSR = "DISABLED" makes SRN follow PUR only; any other value gives GSR & PUR.
module gsr_pur_ctrl #(
  parameter int    PUR_CYCLES     = 16,
  parameter int    GSR_MIN_CYCLES = 4,
  parameter int    SYNC_STAGES    = 2,
  parameter string GSR            = "ENABLED"
) (
  input  logic               SCLK,
  input  logic               RSTN,
  gsr_pur_ctrl_if.slave      bus
);

  localparam int PW = $clog2(PUR_CYCLES + 1);
  localparam int GW = $clog2(GSR_MIN_CYCLES + 1);
  localparam logic [PW-1:0] PUR_MAX  = PW'(PUR_CYCLES);
  localparam logic [GW-1:0] GSR_LOAD = GW'(GSR_MIN_CYCLES);
  localparam bit SRN_PUR_ONLY = (GSR == "DISABLED");

  logic [SYNC_STAGES-1:0] rst_sync_reg;
  logic [SYNC_STAGES-1:0] req_sync_reg;
  logic                   req_prev_reg;
  logic [PW-1:0]          pur_cnt_reg;
  logic [PW-1:0]          pur_cnt_next;
  logic [GW-1:0]          gsr_cnt_reg;
  logic [GW-1:0]          gsr_cnt_next;
  logic                   pur_reg;
  logic                   pur_next;
  logic                   gsr_reg;
  logic                   gsr_next;
  logic                   released;
  logic                   req_s;
  logic                   gsr_load;

  assign released = rst_sync_reg[SYNC_STAGES-1];
  assign req_s    = req_sync_reg[SYNC_STAGES-1];

  always_comb begin
    pur_cnt_next = pur_cnt_reg;
    gsr_cnt_next = gsr_cnt_reg;

    if (released && (pur_cnt_reg != PUR_MAX)) begin
      pur_cnt_next = pur_cnt_reg + 1'b1;
    end
    pur_next = (pur_cnt_next == PUR_MAX);

    // The minimum-width timer starts at the first edge of a request run, so a
    // long request sets the width on its own and the minimum only pads short
    // ones. While PUR is still low the timer is held loaded, so the minimum
    // GSR width is measured from PUR release instead.
    gsr_load = !req_s && (req_prev_reg || !pur_reg);
    if (gsr_load) begin
      gsr_cnt_next = GSR_LOAD;
    end else if (gsr_cnt_reg != '0) begin
      gsr_cnt_next = gsr_cnt_reg - 1'b1;
    end

    gsr_next = pur_next && req_s && (gsr_cnt_next == '0);
  end

  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      rst_sync_reg <= '0;
      req_sync_reg <= '1;
      req_prev_reg <= 1'b1;
      pur_cnt_reg  <= '0;
      gsr_cnt_reg  <= '0;
      pur_reg      <= 1'b0;
      gsr_reg      <= 1'b0;
    end else begin
      rst_sync_reg <= {rst_sync_reg[SYNC_STAGES-2:0], 1'b1};
      req_sync_reg <= {req_sync_reg[SYNC_STAGES-2:0], bus.GSRN_REQ};
      req_prev_reg <= req_s;
      pur_cnt_reg  <= pur_cnt_next;
      gsr_cnt_reg  <= gsr_cnt_next;
      pur_reg      <= pur_next;
      gsr_reg      <= gsr_next;
    end
  end

  assign bus.PUR_sig = pur_reg;
  assign bus.GSR_sig = gsr_reg;
  assign bus.READY   = gsr_reg & pur_reg;

  generate
    if (SRN_PUR_ONLY) begin : g_srn_pur
      assign bus.SRN = pur_reg;
    end else begin : g_srn_both
      assign bus.SRN = gsr_reg & pur_reg;
    end
  endgenerate

endmodule

// File: tb/tb_gsr_pur_ctrl.sv
// tb_gsr_pur_ctrl
// Directed bench for gsr_pur_ctrl with default timing. Two instances share
// SCLK/RSTN: one with GSR="ENABLED", one with GSR="DISABLED".
// Observed vectors are packed as {GSR_sig, PUR_sig, SRN, READY}.
module tb_gsr_pur_ctrl;

  logic SCLK = 1'b0;
  logic RSTN = 1'b0;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  gsr_pur_ctrl_if bus_en ();
  gsr_pur_ctrl_if bus_dis ();

  gsr_pur_ctrl u_dut_en (
    .SCLK (SCLK),
    .RSTN (RSTN),
    .bus  (bus_en)
  );

  gsr_pur_ctrl #(.GSR("DISABLED")) u_dut_dis (
    .SCLK (SCLK),
    .RSTN (RSTN),
    .bus  (bus_dis)
  );

  always #5 SCLK = ~SCLK;

  function automatic logic [3:0] obs_en();
    return {bus_en.GSR_sig, bus_en.PUR_sig, bus_en.SRN, bus_en.READY};
  endfunction

  function automatic logic [3:0] obs_dis();
    return {bus_dis.GSR_sig, bus_dis.PUR_sig, bus_dis.SRN, bus_dis.READY};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed {gsr,pur,srn,ready}=%b expected %b", tag, obs, exp);
  endtask

  // One rising edge, then sample 1 ns later.
  task automatic step();
    @(posedge SCLK);
    #1;
  endtask

  // Release RSTN and expect PUR/GSR to stay low through edge 17 and rise
  // together on edge 18 on both instances.
  task automatic power_up(input string tag);
    logic [3:0] exp;
    @(negedge SCLK);
    RSTN = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      step();
      exp = (n == 18) ? 4'b1111 : 4'b0000;
      check($sformatf("%s_e%0d_en", tag, n), obs_en(), exp);
      check($sformatf("%s_e%0d_dis", tag, n), obs_dis(), exp);
    end
    $display("power-up %s: 18-edge sequence checked", tag);
  endtask

  // Drive a request pattern (bit j-1 low-request before edge j) into one
  // instance and expect GSR_sig low exactly on edges lo_first..lo_last.
  task automatic req_pulse(input string tag, input bit dis, input logic [15:0] mask,
                           input int lo_first, input int lo_last, input int nsteps);
    logic       gsr_e;
    logic [3:0] exp;
    for (int j = 1; j <= nsteps; j++) begin
      if (dis) bus_dis.GSRN_REQ = ~mask[j-1];
      else     bus_en.GSRN_REQ  = ~mask[j-1];
      step();
      gsr_e = !((j >= lo_first) && (j <= lo_last));
      exp   = {gsr_e, 1'b1, (dis ? 1'b1 : gsr_e), gsr_e};
      check($sformatf("%s_e%0d", tag, j), dis ? obs_dis() : obs_en(), exp);
    end
    bus_en.GSRN_REQ  = 1'b1;
    bus_dis.GSRN_REQ = 1'b1;
    $display("request %s: GSR low expected on edges %0d..%0d", tag, lo_first, lo_last);
  endtask

  initial begin
    logic [3:0] exp;
    bus_en.GSRN_REQ  = 1'b1;
    bus_dis.GSRN_REQ = 1'b1;
    RSTN = 1'b0;

    // Reset held for three cycles.
    repeat (3) step();
    check("reset_en", obs_en(), 4'b0000);
    check("reset_dis", obs_dis(), 4'b0000);
    $display("reset: outputs checked low");

    power_up("pwr");

    // Short, long and back-to-back requests on the ENABLED instance.
    req_pulse("short", 1'b0, 16'h0001, 3, 6, 9);
    req_pulse("long", 1'b0, 16'h03FF, 3, 12, 15);
    req_pulse("b2b", 1'b0, 16'h0005, 3, 8, 11);
    // Same short request on the DISABLED instance: SRN must stay high.
    req_pulse("dis_short", 1'b1, 16'h0001, 3, 6, 9);

    // Reset asserted mid power-up at edge 10, between clock edges.
    @(negedge SCLK);
    RSTN = 1'b0;
    repeat (2) step();
    @(negedge SCLK);
    RSTN = 1'b1;
    repeat (10) step();
    #3;
    RSTN = 1'b0;
    #1;
    check("midpwr_rst_en", obs_en(), 4'b0000);
    check("midpwr_rst_dis", obs_dis(), 4'b0000);
    $display("reset at power-up edge 10: outputs checked");
    repeat (2) step();
    power_up("restart1");

    // Reset asserted in the middle of a GSR pulse.
    bus_en.GSRN_REQ = 1'b0;
    step();
    bus_en.GSRN_REQ = 1'b1;
    repeat (3) step();
    check("midgsr_pulse_en", obs_en(), 4'b0100);
    check("midgsr_idle_dis", obs_dis(), 4'b1111);
    #2;
    RSTN = 1'b0;
    #1;
    check("midgsr_rst_en", obs_en(), 4'b0000);
    check("midgsr_rst_dis", obs_dis(), 4'b0000);
    $display("reset during GSR pulse: outputs checked");
    repeat (2) step();
    power_up("restart2");

    // Request held from release through edge 16: PUR rises at 18, GSR waits
    // for the minimum width after PUR release and rises at 22.
    @(negedge SCLK);
    RSTN = 1'b0;
    bus_en.GSRN_REQ = 1'b0;
    repeat (2) step();
    @(negedge SCLK);
    RSTN = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      if (n == 17) bus_en.GSRN_REQ = 1'b1;
      step();
      exp = {(n >= 22), (n >= 18), (n >= 22), (n >= 22)};
      check($sformatf("purwin_e%0d", n), obs_en(), exp);
    end
    $display("request during PUR window: checked through edge 24");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
